// File: rtl/cpu_ctrl.sv
// Instruction sequencer for the 11-bit-address / 14-bit-instruction CPU: fetch/decode/execute
// FSM driving every datapath strobe, plus a saturating retired-instruction counter.
// Optional feature macro: CPU_CTRL_JZ_EN (defined: JZ jumps when acc_zero; undefined: JZ acts as NOP).
module cpu_ctrl #(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             acc_zero,
  output logic             reset_ir,
  output logic             load_mar,
  output logic             mar_sel,
  output logic             load_pc,
  output logic             pc_sel,
  output logic             load_ir,
  output logic             mem_wr,
  output logic             load_acc,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_F1   = 3'd1,
    S_F2   = 3'd2,
    S_F3   = 3'd3,
    S_DEC  = 3'd4,
    S_EX   = 3'd5,
    S_HALT = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(3'd0);
  localparam logic [OP_W-1:0] OP_STA = OP_W'(3'd1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'd2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'd3);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(3'd4);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(3'd5);
  localparam logic [OP_W-1:0] OP_NOP = OP_W'(3'd6);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(3'd7);

  state_t           state_r;
  state_t           next_s;
  logic             retire_s;
  logic             jz_take_s;
  logic [CNT_W-1:0] retired_r;

`ifdef CPU_CTRL_JZ_EN
  assign jz_take_s = acc_zero;
`else
  logic unused_acc_zero_s;
  assign unused_acc_zero_s = acc_zero;
  assign jz_take_s = 1'b0;
`endif

  // State register; reset wins over any in-flight transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state and strobe decode from the registered state (ir_op/acc_zero only in DEC/EX).
  always_comb begin
    next_s   = S_INIT;
    retire_s = 1'b0;
    reset_ir = 1'b0;
    load_mar = 1'b0;
    mar_sel  = 1'b0;
    load_pc  = 1'b0;
    pc_sel   = 1'b0;
    load_ir  = 1'b0;
    mem_wr   = 1'b0;
    load_acc = 1'b0;
    alu_op   = 2'd0;
    halted   = 1'b0;
    case (state_r)
      S_INIT: begin
        reset_ir = 1'b1;
        if (start) next_s = S_F1;
        else       next_s = S_INIT;
      end
      S_F1: begin
        load_mar = 1'b1;
        mar_sel  = 1'b0;
        next_s   = S_F2;
      end
      S_F2: begin
        load_pc = 1'b1;
        pc_sel  = 1'b0;
        next_s  = S_F3;
      end
      S_F3: begin
        load_ir = 1'b1;
        next_s  = S_DEC;
      end
      S_DEC: begin
        case (ir_op)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: begin
            load_mar = 1'b1;
            mar_sel  = 1'b1;
            next_s   = S_EX;
          end
          OP_JMP: begin
            load_pc  = 1'b1;
            pc_sel   = 1'b1;
            retire_s = 1'b1;
            next_s   = S_F1;
          end
          OP_JZ: begin
            if (jz_take_s) begin
              load_pc = 1'b1;
              pc_sel  = 1'b1;
            end else begin
              load_pc = 1'b0;
              pc_sel  = 1'b0;
            end
            retire_s = 1'b1;
            next_s   = S_F1;
          end
          OP_NOP: begin
            retire_s = 1'b1;
            next_s   = S_F1;
          end
          OP_HLT: begin
            retire_s = 1'b1;
            next_s   = S_HALT;
          end
          default: next_s = S_INIT;
        endcase
      end
      S_EX: begin
        case (ir_op)
          OP_LDA: begin
            load_acc = 1'b1;
            alu_op   = 2'd0;
          end
          OP_ADD: begin
            load_acc = 1'b1;
            alu_op   = 2'd1;
          end
          OP_SUB: begin
            load_acc = 1'b1;
            alu_op   = 2'd2;
          end
          OP_STA:  mem_wr = 1'b1;
          default: mem_wr = 1'b0;
        endcase
        retire_s = 1'b1;
        next_s   = S_F1;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) next_s = S_F1;
        else       next_s = S_HALT;
      end
      default: next_s = S_INIT;
    endcase
  end

  // Retired-instruction counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (retire_s && (retired_r != {CNT_W{1'b1}})) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  assign state   = state_r;
  assign retired = retired_r;

endmodule
